// File: rtl/ddr3_traffic_checker_if.sv
// User-side command/response bus between the traffic checker (master) and
// the DDR3 controller (slave).
interface ddr3_traffic_checker_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DQ_W   = 16
);
  logic              write_enable;
  logic              read_enable;
  logic [ADDR_W-1:0] i_user_data_address;
  logic [DQ_W-1:0]   i_user_data;
  logic              cmd_ready;
  logic [DQ_W-1:0]   o_user_data;
  logic              o_user_data_valid;

  modport master (
    output write_enable, read_enable, i_user_data_address, i_user_data,
    input  cmd_ready, o_user_data, o_user_data_valid
  );

  modport slave (
    input  write_enable, read_enable, i_user_data_address, i_user_data,
    output cmd_ready, o_user_data, o_user_data_valid
  );
endinterface

// File: rtl/ddr3_traffic_checker.sv
// Write-then-read-back pattern checker for the DDR3 controller user port, with
// bounded outstanding reads, saturating error count and first-error capture.
module ddr3_traffic_checker #(
  parameter int unsigned ADDRESS_BITWIDTH      = 15,
  parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
  parameter int unsigned DQ_BITWIDTH           = 16,
  parameter int unsigned NUM_OF_ACCESSES       = 256,
  parameter int unsigned MAX_OUTSTANDING_READS = 4,
  parameter int unsigned ERROR_COUNT_BITWIDTH  = 16,
  parameter logic [DQ_BITWIDTH-1:0] LFSR_SEED  = DQ_BITWIDTH'(1),
  parameter logic [DQ_BITWIDTH-1:0] LFSR_TAPS  = DQ_BITWIDTH'(16'hB400)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [1:0]                                      pattern_mode,
  ddr3_traffic_checker_if.master                          mem,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            pass,
  output logic [ERROR_COUNT_BITWIDTH-1:0]                 error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_index,
  output logic                                            protocol_error
);
  localparam int unsigned IDX_W = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING_READS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OF_ACCESSES - 1);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING_READS);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  function automatic logic [DQ_BITWIDTH-1:0] lfsr_step(input logic [DQ_BITWIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [DQ_BITWIDTH-1:0] pattern_word(
    input logic [1:0]             mode,
    input logic [CNT_W-1:0]       k,
    input logic [DQ_BITWIDTH-1:0] lfsr
  );
    logic [DQ_BITWIDTH-1:0] w;
    case (mode)
      2'd0:    w = DQ_BITWIDTH'(k);
      2'd1:    w = lfsr;
      2'd2:    w = DQ_BITWIDTH'(1) << (32'(k) % DQ_BITWIDTH);
      default: w = ~DQ_BITWIDTH'(k);
    endcase
    return w;
  endfunction

  state_e                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cmp_idx_q, cmp_idx_d;
  logic [OUT_W-1:0]          outst_q, outst_d;
  logic [DQ_BITWIDTH-1:0]    gen_lfsr_q, gen_lfsr_d;
  logic [DQ_BITWIDTH-1:0]    cmp_lfsr_q, cmp_lfsr_d;
  logic [ERROR_COUNT_BITWIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]          first_err_q, first_err_d;
  logic                      first_seen_q, first_seen_d;
  logic                      proto_err_q, proto_err_d;
  logic                      we_q, we_d;
  logic                      re_q, re_d;
  logic [IDX_W-1:0]          addr_q, addr_d;
  logic [DQ_BITWIDTH-1:0]    wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      wr_xfer, rd_xfer;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    cmp_idx_d    = cmp_idx_q;
    outst_d      = outst_q;
    gen_lfsr_d   = gen_lfsr_q;
    cmp_lfsr_d   = cmp_lfsr_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
    first_seen_d = first_seen_q;
    proto_err_d  = proto_err_q;
    we_d         = we_q;
    re_d         = re_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_xfer      = we_q & mem.cmd_ready;
    rd_xfer      = re_q & mem.cmd_ready;

    // Outstanding is only nonzero in READ/DRAIN, so a stray valid in any
    // other state falls into the protocol-error branch as well.
    if (mem.o_user_data_valid) begin
      if (outst_q == '0) begin
        proto_err_d = 1'b1;
      end else begin
        outst_d = outst_q - 1'b1;
        if (mem.o_user_data != pattern_word(mode_q, cmp_idx_q, cmp_lfsr_q)) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          if (!first_seen_q) begin
            first_seen_d = 1'b1;
            first_err_d  = cmp_idx_q[IDX_W-1:0];
          end
        end
        cmp_idx_d  = cmp_idx_q + 1'b1;
        cmp_lfsr_d = lfsr_step(cmp_lfsr_q);
      end
    end
    if (rd_xfer) outst_d = outst_d + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WRITE;
          mode_d       = pattern_mode;
          idx_d        = '0;
          cmp_idx_d    = '0;
          outst_d      = '0;
          gen_lfsr_d   = LFSR_SEED;
          cmp_lfsr_d   = LFSR_SEED;
          err_cnt_d    = '0;
          first_err_d  = '0;
          first_seen_d = 1'b0;
          proto_err_d  = 1'b0;
          we_d         = 1'b1;
          re_d         = 1'b0;
          addr_d       = '0;
          wdata_d      = pattern_word(pattern_mode, '0, LFSR_SEED);
        end
      end
      S_WRITE: begin
        if (wr_xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_READ;
            idx_d      = '0;
            cmp_idx_d  = '0;
            gen_lfsr_d = LFSR_SEED;
            cmp_lfsr_d = LFSR_SEED;
            we_d       = 1'b0;
            re_d       = 1'b1;
            addr_d     = '0;
            wdata_d    = '0;
          end else begin
            idx_d      = idx_q + 1'b1;
            gen_lfsr_d = lfsr_step(gen_lfsr_q);
            addr_d     = idx_d[IDX_W-1:0];
            wdata_d    = pattern_word(mode_q, idx_d, gen_lfsr_d);
          end
        end
      end
      S_READ: begin
        if (rd_xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_DRAIN;
        end
        // A held request keeps its slot: outstanding cannot grow without a transfer.
        re_d   = (state_d == S_READ) && (outst_d < MAX_OUT);
        addr_d = (state_d == S_READ) ? idx_d[IDX_W-1:0] : '0;
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_cnt_d == '0) && !proto_err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      idx_q        <= '0;
      cmp_idx_q    <= '0;
      outst_q      <= '0;
      gen_lfsr_q   <= LFSR_SEED;
      cmp_lfsr_q   <= LFSR_SEED;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      first_seen_q <= 1'b0;
      proto_err_q  <= 1'b0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      cmp_idx_q    <= cmp_idx_d;
      outst_q      <= outst_d;
      gen_lfsr_q   <= gen_lfsr_d;
      cmp_lfsr_q   <= cmp_lfsr_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      first_seen_q <= first_seen_d;
      proto_err_q  <= proto_err_d;
      we_q         <= we_d;
      re_q         <= re_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign mem.write_enable        = we_q;
  assign mem.read_enable         = re_q;
  assign mem.i_user_data_address = addr_q;
  assign mem.i_user_data         = wdata_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign pass                    = pass_q;
  assign error_count             = err_cnt_q;
  assign first_error_index       = first_err_q;
  assign protocol_error          = proto_err_q;
endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Bench for ddr3_traffic_checker: behavioural memory/controller model on the
// falling edge, expected patterns computed from index arithmetic.
module tb_ddr3_traffic_checker;
  localparam int unsigned AW   = 15;
  localparam int unsigned BW   = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned IW   = AW + BW;
  localparam int          N    = 16;
  localparam int          MAXO = 4;
  localparam int unsigned EW   = 3;
  localparam logic [DW-1:0] SEED = 16'h0001;
  localparam logic [DW-1:0] TAPS = 16'hB400;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    pattern_mode;
  logic          busy, done, pass, protocol_error;
  logic [EW-1:0] error_count;
  logic [IW-1:0] first_error_index;

  ddr3_traffic_checker_if #(.ADDR_W(IW), .DQ_W(DW)) mem_if ();

  ddr3_traffic_checker #(
    .ADDRESS_BITWIDTH(AW), .BANK_ADDRESS_BITWIDTH(BW), .DQ_BITWIDTH(DW),
    .NUM_OF_ACCESSES(N), .MAX_OUTSTANDING_READS(MAXO), .ERROR_COUNT_BITWIDTH(EW),
    .LFSR_SEED(SEED), .LFSR_TAPS(TAPS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pattern_mode(pattern_mode),
    .mem(mem_if), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_error_index(first_error_index),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [DW-1:0] data; int due; int idx; } resp_t;
  resp_t          resp_q[$];
  logic [DW-1:0]  mem [int];
  int             wr_addr[$], wr_cyc[$], rd_addr[$], rd_cyc[$];
  logic [DW-1:0]  wr_data[$];
  int             cyc = 0, tb_out = 0, max_out = 0, viol_full = 0, viol_both = 0;
  int             ready_mode = 0, lat = 2, flip_idx = -1;
  logic [DW-1:0]  flip_mask = '0;
  bit             flip_all = 0, inject = 0;

  // Reference patterns from the definitions: index arithmetic and k LFSR steps from the seed.
  function automatic logic [DW-1:0] exp_word(input logic [1:0] mode, input int k);
    logic [DW-1:0] s;
    case (mode)
      2'd0: return DW'(k);
      2'd1: begin
        s = SEED;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
        return s;
      end
      2'd2: return DW'(1) << (k % DW);
      default: return ~DW'(k);
    endcase
  endfunction

  function automatic int wlog_bad(input logic [1:0] mode);
    int bad;
    bad = 0;
    if (wr_addr.size() != N) return N;
    for (int k = 0; k < N; k++)
      if (wr_addr[k] != k || wr_data[k] !== exp_word(mode, k)) bad++;
    return bad;
  endfunction

  // Controller/memory model: decides ready and responses for the coming rising edge.
  initial begin
    resp_t r;
    bit real_v;
    mem_if.cmd_ready = 1'b0;
    mem_if.o_user_data_valid = 1'b0;
    mem_if.o_user_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        resp_q.delete();
        tb_out = 0;
      end
      case (ready_mode)
        0:       mem_if.cmd_ready = 1'b1;
        1:       mem_if.cmd_ready = (cyc % 2) == 1;
        default: mem_if.cmd_ready = 1'($urandom_range(0, 1));
      endcase
      real_v = 0;
      mem_if.o_user_data_valid = 1'b0;
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        mem_if.o_user_data = (flip_all || r.idx == flip_idx) ? (r.data ^ flip_mask) : r.data;
        mem_if.o_user_data_valid = 1'b1;
        real_v = 1;
      end else if (inject) begin
        mem_if.o_user_data = DW'($urandom);
        mem_if.o_user_data_valid = 1'b1;
        inject = 0;
      end
      if (mem_if.write_enable && mem_if.read_enable) viol_both++;
      if (mem_if.read_enable && tb_out >= MAXO) viol_full++;
      if (mem_if.write_enable && mem_if.cmd_ready) begin
        mem[int'(mem_if.i_user_data_address)] = mem_if.i_user_data;
        wr_addr.push_back(int'(mem_if.i_user_data_address));
        wr_data.push_back(mem_if.i_user_data);
        wr_cyc.push_back(cyc);
      end
      if (mem_if.read_enable && mem_if.cmd_ready) begin
        resp_q.push_back('{data: mem[int'(mem_if.i_user_data_address)], due: cyc + lat,
                           idx: int'(mem_if.i_user_data_address)});
        rd_addr.push_back(int'(mem_if.i_user_data_address));
        rd_cyc.push_back(cyc);
        tb_out++;
      end
      if (real_v) tb_out--;
      if (tb_out > max_out) max_out = tb_out;
    end
  end

  task automatic run_pass(input logic [1:0] mode, input int rmode, input int latency,
                          input int fidx, input logic [DW-1:0] fmask, input bit fall,
                          output bit finished);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    ready_mode = rmode; lat = latency; flip_idx = fidx; flip_mask = fmask; flip_all = fall;
    max_out = 0; viol_full = 0; viol_both = 0;
    pattern_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finished = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        finished = 1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL done_timeout: done=%0b required 1 within 3000 cycles", done);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, pass, protocol_error, mem_if.write_enable, mem_if.read_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/pass/perr/we/re=%b required 000000",
               {busy, done, pass, protocol_error, mem_if.write_enable, mem_if.read_enable});
    end
    checks++;
    if ({error_count, first_error_index, mem_if.i_user_data_address, mem_if.i_user_data} !== '0) begin
      errors++;
      $display("FAIL reset_values: err=%0d first=%0d addr=%0d data=%h required all 0",
               error_count, first_error_index, mem_if.i_user_data_address, mem_if.i_user_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incrementing;
    bit fin;
    int bad;
    run_pass(2'd0, 0, 2, -1, '0, 0, fin);
    checks++;
    if (wlog_bad(2'd0) != 0) begin
      errors++;
      $display("FAIL inc_writes: bad write entries=%0d required 0", wlog_bad(2'd0));
    end
    bad = (rd_addr.size() != N) ? N : 0;
    for (int k = 0; k < N && bad == 0; k++) if (rd_addr[k] != k) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL inc_read_order: bad read entries=%0d required 0", bad);
    end
    bad = 0;
    if (wr_cyc.size() == N && rd_cyc.size() == N) begin
      for (int k = 0; k < N; k++) begin
        if (wr_cyc[k] != wr_cyc[0] + k) bad++;
        if (rd_cyc[k] != wr_cyc[0] + N + k) bad++;
      end
    end else bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL inc_back_to_back: gapped command cycles=%0d required 0", bad);
    end
    checks++;
    if ({pass, busy, protocol_error, error_count} !== {1'b1, 1'b0, 1'b0, EW'(0)}) begin
      errors++;
      $display("FAIL inc_result: pass=%0b busy=%0b perr=%0b err=%0d required 1 0 0 0",
               pass, busy, protocol_error, error_count);
    end
  endtask

  task automatic test_lfsr;
    bit fin;
    run_pass(2'd1, 2, 3, -1, '0, 0, fin);
    checks++;
    if (wlog_bad(2'd1) != 0) begin
      errors++;
      $display("FAIL lfsr_writes: bad write entries=%0d required 0", wlog_bad(2'd1));
    end
    checks++;
    if (wr_data.size() < 2 || wr_data[0] !== 16'h0001 || wr_data[1] !== 16'hB400) begin
      errors++;
      $display("FAIL lfsr_first_words: got %h %h required 0001 b400",
               (wr_data.size() > 0) ? wr_data[0] : 16'hxxxx,
               (wr_data.size() > 1) ? wr_data[1] : 16'hxxxx);
    end
    checks++;
    if (pass !== 1'b1 || error_count !== '0) begin
      errors++;
      $display("FAIL lfsr_result: pass=%0b err=%0d required 1 0", pass, error_count);
    end
  endtask

  task automatic test_bit_flip;
    bit fin;
    run_pass(2'd2, 0, 2, 5, 16'h0008, 0, fin);
    checks++;
    if (wlog_bad(2'd2) != 0) begin
      errors++;
      $display("FAIL flip_writes: bad write entries=%0d required 0", wlog_bad(2'd2));
    end
    checks++;
    if ({done, pass, error_count, first_error_index} !== {1'b1, 1'b0, EW'(1), IW'(5)}) begin
      errors++;
      $display("FAIL flip_result: done=%0b pass=%0b err=%0d first=%0d required 1 0 1 5",
               done, pass, error_count, first_error_index);
    end
  endtask

  task automatic test_backpressure;
    bit fin;
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    run_pass(m, 1, 10, -1, '0, 0, fin);
    checks++;
    if (max_out != MAXO || viol_full != 0 || viol_both != 0) begin
      errors++;
      $display("FAIL bp_outstanding: max=%0d over_limit_req=%0d both_en=%0d required 4 0 0",
               max_out, viol_full, viol_both);
    end
    checks++;
    if (pass !== 1'b1 || wlog_bad(m) != 0) begin
      errors++;
      $display("FAIL bp_result: pass=%0b bad_writes=%0d required 1 0", pass, wlog_bad(m));
    end
  endtask

  task automatic test_protocol;
    bit fin;
    bit seen;
    seen = 0;
    pattern_mode = 2'd3; ready_mode = 1; lat = 2; flip_idx = -1; flip_all = 0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.write_enable) seen = 1;
    end
    inject = 1;
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (done) fin = 1;
    end
    checks++;
    if ({fin, protocol_error, pass, error_count} !== {1'b1, 1'b1, 1'b0, EW'(0)}) begin
      errors++;
      $display("FAIL proto_flag: done=%0b perr=%0b pass=%0b err=%0d required 1 1 0 0",
               fin, protocol_error, pass, error_count);
    end
    run_pass(2'd3, 0, 2, -1, '0, 0, fin);
    checks++;
    if (protocol_error !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL proto_clear: perr=%0b pass=%0b required 0 1", protocol_error, pass);
    end
  endtask

  task automatic test_reset_mid;
    bit fin;
    bit hit;
    hit = 0;
    ready_mode = 0; lat = 4; flip_idx = -1; flip_all = 0;
    pattern_mode = 2'($urandom_range(0, 3));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (mem_if.read_enable && mem_if.i_user_data_address == IW'(7)) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach_read7: reached=%0b required 1", hit);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, protocol_error, mem_if.write_enable, mem_if.read_enable,
         error_count, first_error_index, mem_if.i_user_data_address, mem_if.i_user_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%0b done=%0b re=%0b addr=%0d err=%0d required all 0",
               busy, done, mem_if.read_enable, mem_if.i_user_data_address, error_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_pass(2'd0, 0, 2, -1, '0, 0, fin);
    checks++;
    if (pass !== 1'b1 || protocol_error !== 1'b0 || wlog_bad(2'd0) != 0) begin
      errors++;
      $display("FAIL mid_recover: pass=%0b perr=%0b required 1 0", pass, protocol_error);
    end
  endtask

  task automatic test_saturation;
    bit fin;
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    run_pass(m, 2, 3, -1, DW'($urandom_range(1, 16'hFFFF)), 1, fin);
    checks++;
    if ({error_count, first_error_index, pass} !== {EW'((1 << EW) - 1), IW'(0), 1'b0}) begin
      errors++;
      $display("FAIL sat_result: err=%0d first=%0d pass=%0b required %0d 0 0",
               error_count, first_error_index, pass, (1 << EW) - 1);
    end
  endtask

  task automatic test_random;
    bit fin;
    logic [1:0] m;
    int fidx, exp_err;
    for (int t = 0; t < 4; t++) begin
      m = 2'($urandom_range(0, 3));
      fidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
      exp_err = (fidx >= 0) ? 1 : 0;
      run_pass(m, 2, int'($urandom_range(1, 12)), fidx, DW'($urandom_range(1, 16'hFFFF)), 0, fin);
      checks++;
      if (wlog_bad(m) != 0 || viol_full != 0 || viol_both != 0) begin
        errors++;
        $display("FAIL rand_cmds[%0d]: bad_writes=%0d over_limit=%0d both=%0d required 0 0 0",
                 t, wlog_bad(m), viol_full, viol_both);
      end
      checks++;
      if ({error_count, first_error_index, pass} !==
          {EW'(exp_err), IW'((fidx >= 0) ? fidx : 0), (exp_err == 0)}) begin
        errors++;
        $display("FAIL rand_result[%0d]: err=%0d first=%0d pass=%0b required %0d %0d %0b",
                 t, error_count, first_error_index, pass, exp_err,
                 (fidx >= 0) ? fidx : 0, exp_err == 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pattern_mode = 2'd0;
    repeat (3) @(negedge clk);
    test_reset;
    test_incrementing;
    test_lfsr;
    test_bit_flip;
    test_backpressure;
    test_protocol;
    test_reset_mid;
    test_saturation;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr3_traffic_checker.md
Name: ddr3_traffic_checker

Overview:
Parametrised successor to the fixed incrementing write-then-read loopback test. The block drives the user-side command interface of ddr3_memory_controller: it writes NUM_OF_ACCESSES words of a selectable data pattern, then reads them back and compares each returned word. It adds a ready/valid handshake, a bounded number of outstanding reads, error counting, and first-error capture. It sits between board-level top logic (switches/LEDs/ILA) and the controller.

Parameters:
ADDRESS_BITWIDTH, 15, DDR row/column address width
BANK_ADDRESS_BITWIDTH, 3, bank address width
DQ_BITWIDTH, 16, user data word width
NUM_OF_ACCESSES, 256, words per pass, 1..2^(ADDRESS_BITWIDTH+BANK_ADDRESS_BITWIDTH)
MAX_OUTSTANDING_READS, 4, read commands in flight, at least 1
ERROR_COUNT_BITWIDTH, 16, saturating error counter width
LFSR_SEED, 1, nonzero seed (DQ_BITWIDTH bits)
LFSR_TAPS, 16'hB400, Galois feedback mask (DQ_BITWIDTH bits)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
start  in  1  level; sampled in IDLE and DONE
pattern_mode  in  2  0=incrementing index, 1=LFSR, 2=walking one, 3=~index; latched on start
write_enable  out  1  write command request
read_enable  out  1  read command request
i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  command address (= index)
i_user_data  out  DQ_BITWIDTH  write data
cmd_ready  in  1  controller accepts the command this cycle
o_user_data  in  DQ_BITWIDTH  read return data
o_user_data_valid  in  1  o_user_data valid, in issue order
busy  out  1  high outside IDLE/DONE
done  out  1  active-high; high in DONE
pass  out  1  done and error_count==0 and no protocol_error
error_count  out  ERROR_COUNT_BITWIDTH  mismatches, saturating
first_error_index  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  index of first mismatch
protocol_error  out  1  sticky; valid received with zero reads outstanding

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; LFSR reset to LFSR_SEED.
- A command transfers on a cycle where (write_enable or read_enable) and cmd_ready. Enable, address, and data are held stable until transfer. Never assert both enables.
- Pattern for index k: mode0 = k truncated to DQ_BITWIDTH; mode1 = k-th LFSR state (state 0 = seed, advance one step per word); mode2 = 1 << (k mod DQ_BITWIDTH); mode3 = ~k truncated.
- IDLE: when start=1, latch pattern_mode, clear error_count/first_error_index/protocol_error, index=0, go to WRITE. Enables first assert the following cycle.
- WRITE: present word for the current index. On transfer, index++. Once the transfer at index NUM_OF_ACCESSES-1 completes, go to READ with issue index 0, compare index 0, and the LFSR re-seeded.
- READ: assert read_enable only while outstanding < MAX_OUTSTANDING_READS and the issue index < NUM_OF_ACCESSES. Outstanding increments on a read transfer and decrements on o_user_data_valid. When both occur in the same cycle, outstanding is unchanged. After the last issue, go to DRAIN.
- Compare on every valid (READ or DRAIN): mismatch against the expected pattern at the compare index increments error_count, which saturates at all-ones. On the first mismatch, capture the compare index. Compare index increments on each valid.
- Valid while outstanding==0: set protocol_error, skip the compare, leave counters unchanged.
- DRAIN: when outstanding reaches 0 after the final valid, go to DONE on the next cycle.
- DONE: done=1, and pass is evaluated. Results hold until start=1, which clears the results and re-enters WRITE.
- Valid in IDLE or WRITE: sets protocol_error only.
- Reset mid-operation: immediate return to IDLE with reset values. Responses still in flight after reset are not tracked.
- Latency: with cmd_ready tied high and a fixed read latency L, a pass takes 1 + N write cycles + N read cycles + drain, when MAX_OUTSTANDING_READS >= L.

Test Plan:
- mode0, N=16, ideal memory model with latency 2, cmd_ready=1: 16 writes carry data 0..15 at addresses 0..15, then 16 reads; done=1, pass=1, error_count=0.
- mode1, N=8, seed 1, taps B400: write data equals the 8-step LFSR sequence; the identical sequence is expected on read; pass=1.
- Flip bit 3 of returned word index 5 in mode2: error_count=1, first_error_index=5, pass=0.
- cmd_ready toggles every other cycle, memory latency 10, MAX_OUTSTANDING_READS=4: read_enable stays low while 4 reads are outstanding; outstanding never exceeds 4; pass=1.
- Inject o_user_data_valid during WRITE: protocol_error=1, pass=0 at DONE; a later start clears protocol_error.
- Assert reset during READ at index 7: the next cycle has state IDLE, all outputs 0; a subsequent start completes a clean pass with pass=1.
